// File: rtl/wfq_tag_sorter_if.sv
// wfq_tag_sorter_if: tag insert / dequeue bundle for the WFQ tag sorter.
//   ins_valid, ins_ftime, ins_flow_id : tag from the finish-time stage
//   deq_req                           : dequeue request from the link side
//   deq_valid, deq_ftime, deq_flow_id : winning (smallest finish time) tag
//   depart                            : departure pulse back to weight/VT stages
//   busy, full, empty, count, drop    : sorter status
// master = producer/consumer side, slave = wfq_tag_sorter.
interface wfq_tag_sorter_if #(
    parameter int N     = 16,
    parameter int IDX_W = 3
);
    logic             ins_valid;
    logic [N-1:0]     ins_ftime;
    logic [N-4:0]     ins_flow_id;
    logic             deq_req;
    logic             deq_valid;
    logic [N-1:0]     deq_ftime;
    logic [N-4:0]     deq_flow_id;
    logic             depart;
    logic             busy;
    logic             full;
    logic             empty;
    logic [IDX_W:0]   count;
    logic             drop;

    modport master (
        output ins_valid, ins_ftime, ins_flow_id, deq_req,
        input  deq_valid, deq_ftime, deq_flow_id, depart,
        input  busy, full, empty, count, drop
    );

    modport slave (
        input  ins_valid, ins_ftime, ins_flow_id, deq_req,
        output deq_valid, deq_ftime, deq_flow_id, depart,
        output busy, full, empty, count, drop
    );
endinterface

// File: rtl/wfq_tag_sorter.sv
// wfq_tag_sorter: holds up to DEPTH (finish time, flow id) tags and, on a
// dequeue request, sequentially scans all slots (one per cycle) for the tag
// with the smallest finish time, emits it with a depart pulse and frees it.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : wfq_tag_sorter_if.slave (insert, dequeue and status signals)
// Optional build macro WFQ_TAG_WRAP_EN: finish times compared as serial
// numbers (MSB of a-b) so wrapped values order correctly; otherwise a plain
// unsigned compare is used.
module wfq_tag_sorter #(
    parameter int N     = 16,
    parameter int DEPTH = 8,
    parameter int IDX_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    wfq_tag_sorter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;

    localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);
    localparam logic [IDX_W:0]   CNT_FULL = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

    state_t           state;
    logic [DEPTH-1:0] valid;
    logic [N-1:0]     slot_ftime [DEPTH];
    logic [N-4:0]     slot_flow  [DEPTH];

    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] best_idx;
    logic             have_best;
    logic [IDX_W-1:0] free_idx;
    logic             free_found;
    logic             ins_acc;
    logic             deq_clr;

    logic [IDX_W:0]   count_q;
    logic [IDX_W:0]   count_nxt;
    logic             full_q;
    logic             empty_q;
    logic             busy_q;
    logic             deq_valid_q;
    logic             drop_q;
    logic [N-1:0]     deq_ftime_q;
    logic [N-4:0]     deq_flow_q;

    function automatic logic precedes(input logic [N-1:0] a, input logic [N-1:0] b);
`ifdef WFQ_TAG_WRAP_EN
        logic [N-1:0] diff;
        diff = a - b;
        return diff[N-1];
`else
        return a < b;
`endif
    endfunction

    // Free slot is taken from the valid vector before this edge's winner is
    // cleared, so an insert in the OUT cycle never lands on the winner.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!valid[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign ins_acc = bus.ins_valid && free_found;
    assign deq_clr = (state == OUT);

    always_comb begin
        count_nxt = count_q;
        if (ins_acc && !deq_clr) begin
            count_nxt = count_q + CNT_ONE;
        end else if (!ins_acc && deq_clr) begin
            count_nxt = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (ins_acc) begin
            slot_ftime[free_idx] <= bus.ins_ftime;
            slot_flow[free_idx]  <= bus.ins_flow_id;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            valid       <= '0;
            scan_idx    <= '0;
            best_idx    <= '0;
            have_best   <= 1'b0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            busy_q      <= 1'b0;
            deq_valid_q <= 1'b0;
            drop_q      <= 1'b0;
            deq_ftime_q <= '0;
            deq_flow_q  <= '0;
        end else begin
            deq_valid_q <= 1'b0;
            drop_q      <= bus.ins_valid && !free_found;
            count_q     <= count_nxt;
            full_q      <= (count_nxt == CNT_FULL);
            empty_q     <= (count_nxt == '0);
            if (ins_acc) begin
                valid[free_idx] <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.deq_req && !empty_q) begin
                        have_best <= 1'b0;
                        scan_idx  <= '0;
                        busy_q    <= 1'b1;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (valid[scan_idx] &&
                        (!have_best || precedes(slot_ftime[scan_idx], slot_ftime[best_idx]))) begin
                        have_best <= 1'b1;
                        best_idx  <= scan_idx;
                    end
                    if (scan_idx == IDX_LAST) begin
                        state <= OUT;
                    end else begin
                        scan_idx <= scan_idx + IDX_ONE;
                    end
                end
                OUT: begin
                    // Only this block clears slots, so the candidate is still valid here.
                    deq_ftime_q     <= slot_ftime[best_idx];
                    deq_flow_q      <= slot_flow[best_idx];
                    deq_valid_q     <= 1'b1;
                    valid[best_idx] <= 1'b0;
                    busy_q          <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.deq_valid   = deq_valid_q;
    assign bus.depart      = deq_valid_q;
    assign bus.deq_ftime   = deq_ftime_q;
    assign bus.deq_flow_id = deq_flow_q;
    assign bus.busy        = busy_q;
    assign bus.full        = full_q;
    assign bus.empty       = empty_q;
    assign bus.count       = count_q;
    assign bus.drop        = drop_q;
endmodule

// File: tb/tb_wfq_tag_sorter.sv
// Self-checking bench for wfq_tag_sorter: table-driven ordering/tie vectors,
// hand-written corner sequences and a randomized run against a slot model.
module tb_wfq_tag_sorter;
    localparam int N     = 16;
    localparam int DEPTH = 8;
    localparam int IDX_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wfq_tag_sorter_if #(.N(N), .IDX_W(IDX_W)) bus ();

    wfq_tag_sorter #(.N(N), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int dv_cnt = 0;

    always @(negedge clk) begin
        if (bus.deq_valid === 1'b1) dv_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ins(input logic [N-1:0] ft, input logic [N-4:0] fl);
        bus.ins_valid   = 1'b1;
        bus.ins_ftime   = ft;
        bus.ins_flow_id = fl;
        tick();
        bus.ins_valid   = 1'b0;
    endtask

    task automatic deq(output bit got, output bit dep, output logic [N-1:0] ft,
                       output logic [N-4:0] fl, output int lat);
        bus.deq_req = 1'b1;
        tick();
        bus.deq_req = 1'b0;
        got = 0; dep = 0; lat = 0; ft = '0; fl = '0;
        for (int i = 1; i <= 20 && !got; i++) begin
            tick();
            if (bus.deq_valid === 1'b1) begin
                got = 1; lat = i;
                dep = bus.depart;
                ft  = bus.deq_ftime;
                fl  = bus.deq_flow_id;
            end
        end
    endtask

    task automatic deq_chk(input logic [N-1:0] eft, input logic [N-4:0] efl, input int ecnt);
        bit got, dep;
        logic [N-1:0] ft;
        logic [N-4:0] fl;
        int lat;
        deq(got, dep, ft, fl, lat);
        chk("deq_seen", 32'(got), 32'd1);
        if (got) begin
            chk("deq_latency", 32'(lat), 32'd9);
            chk("deq_depart", 32'(dep), 32'd1);
            chk("deq_ftime", 32'(ft), 32'(eft));
            chk("deq_flow", 32'(fl), 32'(efl));
            chk("deq_count", 32'(bus.count), 32'(ecnt));
            tick();
            chk("deq_pulse_end", 32'(bus.deq_valid), 32'd0);
            tick();
        end
    endtask

    typedef struct {
        bit           is_deq;
        logic [N-1:0] ftime;
        logic [N-4:0] flow;
        int           exp_count;
    } vec_t;

    // reference model: slot-addressed storage
    bit           mv  [DEPTH];
    logic [N-1:0] mf  [DEPTH];
    logic [N-4:0] mfl [DEPTH];
    int           mcnt;

    initial begin
        vec_t tbl [10];
        int d0;
        logic [N-1:0] first_ft, second_ft;

        bus.ins_valid = 1'b0; bus.ins_ftime = '0; bus.ins_flow_id = '0; bus.deq_req = 1'b0;

        // reset
        repeat (3) tick();
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_deq_valid", 32'(bus.deq_valid), 32'd0);
        chk("rst_depart", 32'(bus.depart), 32'd0);
        chk("rst_drop", 32'(bus.drop), 32'd0);
        chk("rst_deq_ftime", 32'(bus.deq_ftime), 32'd0);
        chk("rst_deq_flow", 32'(bus.deq_flow_id), 32'd0);
        rst = 1'b1;
        tick();

        // dequeue on empty
        d0 = dv_cnt;
        bus.deq_req = 1'b1;
        tick();
        bus.deq_req = 1'b0;
        chk("empty_deq_busy", 32'(bus.busy), 32'd0);
        repeat (12) tick();
        chk("empty_deq_no_valid", 32'(dv_cnt - d0), 32'd0);
        chk("empty_deq_count", 32'(bus.count), 32'd0);

        // ordering and tie vectors
        tbl[0] = '{0, 16'h0300, 13'd5, 1};
        tbl[1] = '{0, 16'h0100, 13'd2, 2};
        tbl[2] = '{0, 16'h0200, 13'd7, 3};
        tbl[3] = '{1, 16'h0100, 13'd2, 2};
        tbl[4] = '{1, 16'h0200, 13'd7, 1};
        tbl[5] = '{1, 16'h0300, 13'd5, 0};
        tbl[6] = '{0, 16'h0050, 13'd1, 1};
        tbl[7] = '{0, 16'h0050, 13'd4, 2};
        tbl[8] = '{1, 16'h0050, 13'd1, 1};
        tbl[9] = '{1, 16'h0050, 13'd4, 0};
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].is_deq) begin
                deq_chk(tbl[i].ftime, tbl[i].flow, tbl[i].exp_count);
            end else begin
                ins(tbl[i].ftime, tbl[i].flow);
                chk("tbl_ins_count", 32'(bus.count), 32'(tbl[i].exp_count));
            end
        end

        // full / drop
        for (int i = 0; i < DEPTH; i++) ins(N'(16'h1000 + i * 16'h10), (N-3)'(i));
        chk("full_flag", 32'(bus.full), 32'd1);
        chk("full_count", 32'(bus.count), 32'd8);
        ins(16'h0001, 13'd12);
        chk("drop_pulse", 32'(bus.drop), 32'd1);
        chk("drop_count", 32'(bus.count), 32'd8);
        tick();
        chk("drop_pulse_end", 32'(bus.drop), 32'd0);
        deq_chk(16'h1000, 13'd0, 7);
        ins(16'h2000, 13'd9);
        chk("refill_no_drop", 32'(bus.drop), 32'd0);
        chk("refill_count", 32'(bus.count), 32'd8);
        for (int i = 1; i < DEPTH; i++) deq_chk(N'(16'h1000 + i * 16'h10), (N-3)'(i), DEPTH - i);
        deq_chk(16'h2000, 13'd9, 0);
        chk("drain_empty", 32'(bus.empty), 32'd1);

        // insert in the OUT cycle
        ins(16'h0400, 13'd3);
        bus.deq_req = 1'b1;
        tick();
        bus.deq_req = 1'b0;
        repeat (8) tick();
        bus.ins_valid = 1'b1; bus.ins_ftime = 16'h0100; bus.ins_flow_id = 13'd6;
        tick();
        bus.ins_valid = 1'b0;
        chk("out_ins_valid", 32'(bus.deq_valid), 32'd1);
        chk("out_ins_ftime", 32'(bus.deq_ftime), 32'h0400);
        chk("out_ins_flow", 32'(bus.deq_flow_id), 32'd3);
        chk("out_ins_count", 32'(bus.count), 32'd1);
        tick();
        deq_chk(16'h0100, 13'd6, 0);

        // deq_req while busy is ignored
        ins(16'h0010, 13'd1);
        ins(16'h0020, 13'd2);
        d0 = dv_cnt;
        bus.deq_req = 1'b1;
        tick();
        bus.deq_req = 1'b0;
        repeat (3) tick();
        bus.deq_req = 1'b1;
        tick();
        bus.deq_req = 1'b0;
        repeat (20) tick();
        chk("busy_req_one_valid", 32'(dv_cnt - d0), 32'd1);
        chk("busy_req_count", 32'(bus.count), 32'd1);
        deq_chk(16'h0020, 13'd2, 0);

        // reset mid-scan
        ins(16'h0033, 13'd8);
        d0 = dv_cnt;
        bus.deq_req = 1'b1;
        tick();
        bus.deq_req = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("midrst_empty", 32'(bus.empty), 32'd1);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (15) tick();
        chk("midrst_no_valid", 32'(dv_cnt - d0), 32'd0);
        chk("midrst_count", 32'(bus.count), 32'd0);

        // wrap ordering
`ifdef WFQ_TAG_WRAP_EN
        first_ft = 16'hFFF0; second_ft = 16'h0010;
`else
        first_ft = 16'h0010; second_ft = 16'hFFF0;
`endif
        ins(16'hFFF0, 13'd1);
        ins(16'h0010, 13'd2);
        deq_chk(first_ft, (first_ft == 16'hFFF0) ? 13'd1 : 13'd2, 1);
        deq_chk(second_ft, (second_ft == 16'hFFF0) ? 13'd1 : 13'd2, 0);

        // randomized run against the slot model (tags span < 2**(N-1))
        for (int s = 0; s < DEPTH; s++) mv[s] = 0;
        mcnt = 0;
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 99) < 55) begin
                logic [N-1:0] ft;
                logic [N-4:0] fl;
                ft = $urandom_range(0, 1) ? N'($urandom_range(0, 16'h3FFF))
                                          : N'($urandom_range(0, 7) * 16'h100);
                fl = (N-3)'($urandom);
                ins(ft, fl);
                if (mcnt == DEPTH) begin
                    chk("rnd_drop", 32'(bus.drop), 32'd1);
                end else begin
                    chk("rnd_no_drop", 32'(bus.drop), 32'd0);
                    for (int s = 0; s < DEPTH; s++) begin
                        if (!mv[s]) begin
                            mv[s] = 1; mf[s] = ft; mfl[s] = fl; mcnt++;
                            break;
                        end
                    end
                end
            end else if (mcnt == 0) begin
                bit got, dep;
                logic [N-1:0] ft;
                logic [N-4:0] fl;
                int lat;
                deq(got, dep, ft, fl, lat);
                chk("rnd_empty_deq", 32'(got), 32'd0);
            end else begin
                logic [N-1:0] minv;
                int win;
                minv = '1;
                for (int s = 0; s < DEPTH; s++) if (mv[s] && mf[s] < minv) minv = mf[s];
                win = -1;
                for (int s = DEPTH - 1; s >= 0; s--) if (mv[s] && mf[s] == minv) win = s;
                mv[win] = 0;
                mcnt--;
                deq_chk(mf[win], mfl[win], mcnt);
            end
            chk("rnd_count", 32'(bus.count), 32'(mcnt));
            chk("rnd_full", 32'(bus.full), 32'(mcnt == DEPTH));
            chk("rnd_empty", 32'(bus.empty), 32'(mcnt == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
